// File: rtl/control_unit_pkg.sv
// Shared types and constants for the control_unit sequencer: state encoding,
// opcode values, decoded path kinds and the fixed program ROM.
package control_unit_pkg;

    typedef enum logic [3:0] {
        IDLE,
        S_IF,
        S_ID,
        S_REG,
        S_EX,
        S_MEM,
        S_WB,
        S_JU,
        S_BR,
        S_SK
    } state_t;

    typedef enum logic [2:0] {
        PATH_R,
        PATH_LW,
        PATH_SW,
        PATH_BEQ,
        PATH_J,
        PATH_SK
    } path_t;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_NOP = 6'h3F;

    typedef struct packed {
        logic [5:0] opcode;
        logic [3:0] target;
    } instr_t;

    localparam instr_t ROM [16] = '{
        '{OP_R,   4'd0},
        '{OP_LW,  4'd0},
        '{OP_SW,  4'd0},
        '{OP_BEQ, 4'd0},
        '{OP_NOP, 4'd0},
        '{OP_J,   4'd0},
        '{OP_NOP, 4'd0},
        '{OP_NOP, 4'd0},
        '{OP_NOP, 4'd0},
        '{OP_NOP, 4'd0},
        '{OP_NOP, 4'd0},
        '{OP_NOP, 4'd0},
        '{OP_NOP, 4'd0},
        '{OP_NOP, 4'd0},
        '{OP_NOP, 4'd0},
        '{OP_NOP, 4'd0}
    };

    function automatic instr_t rom_read(input logic [3:0] addr);
        return ROM[addr];
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational opcode-to-path mapping; unknown opcodes take the skip path.
module cu_decode
    import control_unit_pkg::*;
(
    input  logic [5:0] opcode,
    output path_t      path
);

    always_comb begin
        path = PATH_SK;
        case (opcode)
            OP_R:    path = PATH_R;
            OP_LW:   path = PATH_LW;
            OP_SW:   path = PATH_SW;
            OP_BEQ:  path = PATH_BEQ;
            OP_J:    path = PATH_J;
            default: path = PATH_SK;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction-stage sequencer: walks the ROM program one stage per run cycle,
// records retired instructions in a bitmap and offers a registered readback.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        top_en,
    input  logic        infer,
    input  logic [15:0] infer_addr,
    output logic        IF,
    output logic        ID,
    output logic        REG,
    output logic        EX,
    output logic        MEM,
    output logic        WB,
    output logic        JU,
    output logic        BR,
    output logic        SK,
    output logic        infer_data
);

    state_t      state, state_next;
    logic [3:0]  pc, pc_next;
    logic [15:0] bitmap, bitmap_next;
    instr_t      instr;
    path_t       path;
    logic        run;
    logic        stage_en;
    logic        retire;

    assign run      = top_en & ~infer;
    assign stage_en = run & ~rst;
    assign instr    = rom_read(pc);

    cu_decode u_decode (
        .opcode (instr.opcode),
        .path   (path)
    );

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        bitmap_next = bitmap;
        retire      = 1'b0;
        if (run) begin
            case (state)
                IDLE:  state_next = S_IF;
                S_IF:  state_next = S_ID;
                S_ID: begin
                    if (path == PATH_J)       state_next = S_JU;
                    else if (path == PATH_SK) state_next = S_SK;
                    else                      state_next = S_REG;
                end
                S_REG: state_next = (path == PATH_BEQ) ? S_BR : S_EX;
                S_EX:  state_next = (path == PATH_R) ? S_WB : S_MEM;
                S_MEM: begin
                    if (path == PATH_LW) state_next = S_WB;
                    else                 retire     = 1'b1;
                end
                S_WB, S_JU, S_BR, S_SK: retire = 1'b1;
                default: state_next = IDLE;
            endcase
        end
        // Retirement is the only place pc and the bitmap change.
        if (retire) begin
            state_next  = S_IF;
            bitmap_next = bitmap | (16'h0001 << pc);
            pc_next     = (path == PATH_J) ? instr.target : pc + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= 4'd0;
            bitmap     <= 16'h0000;
            infer_data <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            bitmap     <= bitmap_next;
            infer_data <= infer && (infer_addr < 16'd16) && bitmap[infer_addr[3:0]];
        end
    end

    assign IF  = stage_en && (state == S_IF);
    assign ID  = stage_en && (state == S_ID);
    assign REG = stage_en && (state == S_REG);
    assign EX  = stage_en && (state == S_EX);
    assign MEM = stage_en && (state == S_MEM);
    assign WB  = stage_en && (state == S_WB);
    assign JU  = stage_en && (state == S_JU);
    assign BR  = stage_en && (state == S_BR);
    assign SK  = stage_en && (state == S_SK);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        top_en = 1'b0;
    logic        infer = 1'b0;
    logic [15:0] infer_addr = 16'd0;
    logic        IF, ID, REG, EX, MEM, WB, JU, BR, SK;
    logic        infer_data;

    int checks = 0;
    int errors = 0;

    localparam logic [8:0] Z    = 9'b000000000;
    localparam logic [8:0] P_IF = 9'b100000000;
    localparam logic [8:0] P_ID = 9'b010000000;
    localparam logic [8:0] P_RG = 9'b001000000;
    localparam logic [8:0] P_EX = 9'b000100000;
    localparam logic [8:0] P_MM = 9'b000010000;
    localparam logic [8:0] P_WB = 9'b000001000;
    localparam logic [8:0] P_JU = 9'b000000100;
    localparam logic [8:0] P_BR = 9'b000000010;
    localparam logic [8:0] P_SK = 9'b000000001;

    // Hand-written 26-cycle program loop: pc0 R, pc1 LW, pc2 SW, pc3 BEQ, pc4 skip, pc5 J.
    localparam logic [8:0] LOOP [26] = '{
        P_IF, P_ID, P_RG, P_EX, P_WB,
        P_IF, P_ID, P_RG, P_EX, P_MM, P_WB,
        P_IF, P_ID, P_RG, P_EX, P_MM,
        P_IF, P_ID, P_RG, P_BR,
        P_IF, P_ID, P_SK,
        P_IF, P_ID, P_JU
    };

    typedef struct {
        logic [8:0] strb;
        logic       idata;
        string      name;
    } exp_t;

    exp_t sb [$];

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .top_en     (top_en),
        .infer      (infer),
        .infer_addr (infer_addr),
        .IF         (IF),
        .ID         (ID),
        .REG        (REG),
        .EX         (EX),
        .MEM        (MEM),
        .WB         (WB),
        .JU         (JU),
        .BR         (BR),
        .SK         (SK),
        .infer_data (infer_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        logic [8:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {IF, ID, REG, EX, MEM, WB, JU, BR, SK};
            checks++;
            if (act !== e.strb || infer_data !== e.idata) begin
                errors++;
                $display("FAIL %s @%0t: strobes=%b infer_data=%b, expected strobes=%b infer_data=%b",
                         e.name, $time, act, infer_data, e.strb, e.idata);
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic i, input logic [15:0] a,
                       input logic [8:0] s, input logic d, input string nm);
        exp_t x;
        rst        = r;
        top_en     = e;
        infer      = i;
        infer_addr = a;
        x.strb  = s;
        x.idata = d;
        x.name  = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic run_loop(input int start, input int n, input string nm);
        for (int k = 0; k < n; k++)
            cyc(1'b0, 1'b1, 1'b0, 16'd0, LOOP[(start + k) % 26], 1'b0, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, scoreboard depth=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset then enable low: everything quiet.
        for (int k = 0; k < 2; k++) cyc(1'b1, 1'b0, 1'b0, 16'd0, Z, 1'b0, "reset");
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 16'd0, Z, 1'b0, "en_low");

        // First run cycle leaves IDLE without a strobe, then the full loop and a wrap to pc0.
        cyc(1'b0, 1'b1, 1'b0, 16'd0, Z, 1'b0, "idle_exit");
        run_loop(0, 26, "loop1");
        run_loop(0, 3, "loop2_pre");

        // Freeze at EX for three cycles, then EX re-strobes.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 16'd0, Z, 1'b0, "stall_ex");
        run_loop(3, 10, "loop2_post");

        // Readback after 40 run cycles; infer_data lags the address by one cycle.
        cyc(1'b0, 1'b1, 1'b1, 16'd3,    Z, 1'b0, "rb_a3");
        cyc(1'b0, 1'b1, 1'b1, 16'd9,    Z, 1'b1, "rb_d3");
        cyc(1'b0, 1'b1, 1'b1, 16'd6301, Z, 1'b0, "rb_d9");
        cyc(1'b0, 1'b1, 1'b1, 16'd16,   Z, 1'b0, "rb_d6301");
        cyc(1'b0, 1'b1, 1'b1, 16'd5,    Z, 1'b0, "rb_d16");
        cyc(1'b0, 1'b1, 1'b1, 16'd15,   Z, 1'b1, "rb_d5");
        cyc(1'b0, 1'b1, 1'b0, 16'd0, LOOP[13], 1'b0, "rb_d15_resume");

        // Continue to the LW MEM stage of the next pass and reset there.
        run_loop(14, 12, "loop2_tail");
        run_loop(0, 9, "loop3_pre");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, Z, 1'b0, "rst_at_mem");
        cyc(1'b0, 1'b1, 1'b0, 16'd0, Z, 1'b0, "idle_after_rst");
        cyc(1'b0, 1'b1, 1'b1, 16'd1, Z, 1'b0, "rb_a1_after_rst");
        cyc(1'b0, 1'b1, 1'b0, 16'd0, P_IF, 1'b0, "rb_d1_after_rst");
        run_loop(1, 4, "pc0_after_rst");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The module SHALL have exactly one clock, with a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 top_en  input  1  run enable; 0 stalls sequencing.
REQ-005 infer  input  1  inference/readback mode; 1 stalls sequencing and enables readback.
REQ-006 infer_addr  input  16  readback address.
REQ-007 IF, ID, REG, EX, MEM, WB, JU, BR, SK  output  1 each  stage strobes: fetch, decode, register read, execute, memory, writeback, jump, branch, skip.
REQ-008 infer_data  output  1  registered readback bit.

Function
REQ-009 The FSM SHALL have states IDLE, S_IF, S_ID, S_REG, S_EX, S_MEM, S_WB, S_JU, S_BR, S_SK, plus a 4-bit pc and a 16-bit retired bitmap.
REQ-010 run = top_en AND NOT infer; when run=0, the state, pc and bitmap SHALL hold and all stage strobes SHALL be 0.
REQ-011 Each strobe SHALL equal (state == its stage) AND run; at most one strobe is high in any cycle.
REQ-012 IDLE → S_IF on the first edge with run=1.
REQ-013 Each stage SHALL last exactly one run cycle; the instruction word is read from ROM[pc] (6-bit opcode, 4-bit target).
REQ-014 Path after S_IF→S_ID is set by opcode: 0x00 R-type: REG,EX,WB; 0x23 LW: REG,EX,MEM,WB; 0x2B SW: REG,EX,MEM; 0x04 BEQ: REG,BR; 0x02 J: JU; any other opcode: SK.
REQ-015 Retire (last stage of a path) SHALL set bitmap[pc] and go to S_IF; pc <= target on J, else pc <= pc+1 with wrap 15→0.
REQ-016 infer_data SHALL be registered each cycle: infer AND (infer_addr < 16) AND bitmap[infer_addr[3:0]]; it is 0 when infer=0 or infer_addr ≥ 16.
REQ-017 Readback latency: one cycle from infer/infer_addr to infer_data.
REQ-018 top_en falling mid-instruction SHALL freeze at the current stage; the stage re-strobes when run returns.

Reset
REQ-019 rst SHALL force state=IDLE, pc=0, bitmap=0, infer_data=0 and all strobes 0; rst has priority over run and infer.
REQ-020 Reset asserted mid-instruction SHALL abandon the instruction without setting its bitmap bit.

Structure
REQ-021 A shared package control_unit_pkg SHALL hold the state enum, opcode constants, and the 16-entry program ROM constant.
REQ-022 Default ROM: [0]=0x00, [1]=0x23, [2]=0x2B, [3]=0x04, [4]=0x3F, [5]=0x02 with target 0; all other entries 0x3F.
REQ-023 Sub-module cu_decode SHALL be the only sub-module: a combinational opcode-to-path mapping.

Verification
REQ-024 rst=1 for 2 cycles, then top_en=0 for 5 cycles: all outputs stay 0, state stays IDLE.
REQ-025 top_en=1 from reset: strobes follow IF,ID,REG,EX,WB (pc0); IF,ID,REG,EX,MEM,WB (pc1); IF,ID,REG,EX,MEM (pc2); IF,ID,REG,BR (pc3); IF,ID,SK (pc4); IF,ID,JU (pc5); then IF again at pc0, a 26-cycle loop.
REQ-026 top_en dropped for 3 cycles during S_EX: strobes are 0 for those 3 cycles, then EX is strobed once and the sequence continues.
REQ-027 After 40 run cycles, infer=1 with infer_addr=3: the next cycle infer_data=1 and all strobes are 0; infer_addr=9 gives 0; infer_addr=6301 gives 0.
REQ-028 rst pulsed during the LW MEM stage: IDLE next cycle; after infer=1 with infer_addr=1, infer_data=0.
